credit_arbiter: RTL and testbench

CREDIT_ARBITER -- requirements
Module: credit_arbiter

---
 rtl/credit_arbiter_if.sv | 58 +++++
 rtl/credit_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_credit_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/credit_arbiter_if.sv
// -----------------------------------------------------------------------------
// credit_arbiter_if
//   Bundles the requester-side and downstream-side handshake signals of the
//   credit arbiter.
//
//   Handshake rule (applies to every requester lane i):
//     A word moves on a re_clk edge where req_valid[i] and req_ready[i] are
//     both high. req_valid[i] may rise at any time. req_ready[i] is a
//     combinational strobe that may depend on req_valid. At most one
//     req_ready bit is high in any cycle. Downstream, re_valid is a one-cycle
//     write strobe with no back-pressure. Buffer space is returned through
//     re_credit_pulse, one cycle high per freed slot.
//
//   Signals
//     req_valid       [NUM_REQ]        requester i has a word
//     req_last        [NUM_REQ]        word from requester i ends its burst
//     req_data        [NUM_REQ*WIDTH]  word i at bits [i*WIDTH +: WIDTH]
//     req_ready       [NUM_REQ]        one-hot accept strobe
//     re_credit_pulse [1]              one downstream slot freed
//     re_valid        [1]              registered write strobe downstream
//     data_in         [WIDTH]          registered word downstream
//
//   Modports
//     slave  : the arbiter side
//     master : the requesters plus the downstream buffer (the bench)
// -----------------------------------------------------------------------------
interface credit_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_last;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     re_credit_pulse;
   logic                     re_valid;
   logic [WIDTH-1:0]         data_in;

   modport slave (
      input  req_valid,
      input  req_last,
      input  req_data,
      input  re_credit_pulse,
      output req_ready,
      output re_valid,
      output data_in
   );

   modport master (
      output req_valid,
      output req_last,
      output req_data,
      output re_credit_pulse,
      input  req_ready,
      input  re_valid,
      input  data_in
   );
endinterface

// File: rtl/credit_arbiter.sv
// -----------------------------------------------------------------------------
// credit_arbiter
//   Round-robin arbiter with burst locking that forwards one word per cycle
//   into a downstream buffer of CREDITS slots. It only accepts a word while at
//   least one credit remains. Credits come back through re_credit_pulse.
//
//   Ports
//     re_clk        clock
//     re_reset_n    asynchronous active-low reset
//     arb_enable    grants allowed when high
//     bus           credit_arbiter_if.slave (requester and downstream signals)
//     grant_id      index of the last accepted requester
//     credit_count  credits currently available
//     credit_err    sticky flag: credit returned while already full
//     state_dbg     FSM state (0 = IDLE, 1 = BURST)
//     stat_words    (CREDIT_ARB_STATS_EN only) accepted-word counter
//     stat_stall    (CREDIT_ARB_STATS_EN only) starved-by-credit cycle counter
//
//   Optional feature macro: CREDIT_ARB_STATS_EN
// -----------------------------------------------------------------------------
module credit_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int CREDITS = 16,
   parameter int CNT_W   = $clog2(CREDITS + 1)
) (
   input  logic                       re_clk,
   input  logic                       re_reset_n,
   input  logic                       arb_enable,
   credit_arbiter_if.slave            bus,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic [CNT_W-1:0]           credit_count,
   output logic                       credit_err,
   output logic [0:0]                 state_dbg
`ifdef CREDIT_ARB_STATS_EN
   ,
   output logic [31:0]                stat_words,
   output logic [31:0]                stat_stall
`endif
);

   localparam int GID_W = $clog2(NUM_REQ);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [0:0]       state;
   logic [GID_W-1:0] cand;
   logic [GID_W-1:0] win_idx;
   logic             win_found;
   logic [WIDTH-1:0] win_data;
   logic             win_last;
   logic             can_grant;
   logic             xfer;

   // ---------------------------------------------------------------------------
   // Winner selection.
   // In IDLE, the search starts one past the last grant and wraps. In BURST,
   // only the locked requester can win, so a burst is never interleaved.
   // ---------------------------------------------------------------------------
   always_comb begin
      cand      = '0;
      win_idx   = '0;
      win_found = 1'b0;
      if (state == ST_BURST) begin
         win_idx   = grant_id;
         win_found = bus.req_valid[grant_id];
      end else begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GID_W'((32'(grant_id) + 32'(k)) % 32'(NUM_REQ));
            if (!win_found && bus.req_valid[cand]) begin
               win_found = 1'b1;
               win_idx   = cand;
            end
         end
      end
   end

   // Mux the winner's word and last flag out of the flattened request bus.
   always_comb begin
      win_data = '0;
      win_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == GID_W'(i)) begin
            win_data = bus.req_data[i*WIDTH +: WIDTH];
            win_last = bus.req_last[i];
         end
      end
   end

   // The reset term keeps req_ready low while reset is held. Without it,
   // ready would follow the reset value of credit_count, which is full.
   assign can_grant = re_reset_n && arb_enable && (credit_count != '0);
   assign xfer      = can_grant && win_found;

   always_comb begin
      bus.req_ready = '0;
      if (xfer) begin
         bus.req_ready = NUM_REQ'(1) << win_idx;
      end
   end

   // ---------------------------------------------------------------------------
   // Burst-lock FSM. The lock follows req_last of each accepted word.
   // A stall (no credit or not enabled) leaves the state unchanged.
   // ---------------------------------------------------------------------------
   always_ff @(posedge re_clk or negedge re_reset_n) begin
      if (!re_reset_n) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (xfer && !win_last) begin
                  state <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (xfer && win_last) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign state_dbg = state;

   // ---------------------------------------------------------------------------
   // Output register and grant pointer.
   // grant_id resets to NUM_REQ-1, so requester 0 is searched first.
   // ---------------------------------------------------------------------------
   always_ff @(posedge re_clk or negedge re_reset_n) begin
      if (!re_reset_n) begin
         bus.re_valid <= 1'b0;
         bus.data_in  <= '0;
         grant_id     <= GID_W'(NUM_REQ - 1);
      end else begin
         bus.re_valid <= xfer;
         if (xfer) begin
            bus.data_in <= win_data;
            grant_id    <= win_idx;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Credit accounting. A transfer and a pulse in the same cycle cancel out.
   // A pulse arriving while already full is a protocol error downstream. The
   // count saturates and the error flag sticks until reset.
   // ---------------------------------------------------------------------------
   always_ff @(posedge re_clk or negedge re_reset_n) begin
      if (!re_reset_n) begin
         credit_count <= CNT_FULL;
         credit_err   <= 1'b0;
      end else begin
         case ({xfer, bus.re_credit_pulse})
            2'b10: credit_count <= credit_count - CNT_ONE;
            2'b01: begin
               if (credit_count == CNT_FULL) begin
                  credit_err <= 1'b1;
               end else begin
                  credit_count <= credit_count + CNT_ONE;
               end
            end
            default: credit_count <= credit_count;
         endcase
      end
   end

`ifdef CREDIT_ARB_STATS_EN
   // ---------------------------------------------------------------------------
   // Free-running statistics. Both counters wrap.
   // A stall cycle means work was waiting, the arbiter was enabled, and
   // credits were the only thing missing.
   // ---------------------------------------------------------------------------
   logic stall_cycle;

   assign stall_cycle = (|bus.req_valid) && arb_enable && (credit_count == '0);

   always_ff @(posedge re_clk or negedge re_reset_n) begin
      if (!re_reset_n) begin
         stat_words <= 32'd0;
         stat_stall <= 32'd0;
      end else begin
         if (xfer) begin
            stat_words <= stat_words + 32'd1;
         end
         if (stall_cycle) begin
            stat_stall <= stat_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_credit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_credit_arbiter
//   Self-checking bench for credit_arbiter (NUM_REQ=4, WIDTH=32, CREDITS=16).
//   Inputs change on the falling edge. req_ready is checked 1 time unit later.
//   Registered outputs are checked 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_credit_arbiter;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int C  = 16;
   localparam int CW = 5;
   localparam int SW = 42;

   logic          re_clk = 1'b0;
   logic          re_reset_n;
   logic          arb_enable;
   logic [1:0]    grant_id;
   logic [CW-1:0] credit_count;
   logic          credit_err;
   logic [0:0]    state_dbg;
`ifdef CREDIT_ARB_STATS_EN
   logic [31:0]   stat_words;
   logic [31:0]   stat_stall;
`endif

   credit_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

   credit_arbiter #(.NUM_REQ(N), .WIDTH(W), .CREDITS(C), .CNT_W(CW)) dut (
      .re_clk       (re_clk),
      .re_reset_n   (re_reset_n),
      .arb_enable   (arb_enable),
      .bus          (bus),
      .grant_id     (grant_id),
      .credit_count (credit_count),
      .credit_err   (credit_err),
      .state_dbg    (state_dbg)
`ifdef CREDIT_ARB_STATS_EN
      ,
      .stat_words   (stat_words),
      .stat_stall   (stat_stall)
`endif
   );

   // clock / reset
   always #5 re_clk = ~re_clk;

   int total = 0;
   int bad   = 0;

   logic [SW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic apply(input logic en, input logic [3:0] v, input logic [3:0] l, input logic p);
      @(negedge re_clk);
      arb_enable          = en;
      bus.req_valid       = v;
      bus.req_last        = l;
      bus.re_credit_pulse = p;
      #1;
   endtask

   task automatic tick();
      @(posedge re_clk);
      #1;
   endtask

   task automatic set_fixed_data();
      for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = 32'hD000_0000 + 32'(i);
   endtask

   task automatic do_reset(input string tag);
      @(negedge re_clk);
      arb_enable          = 1'b0;
      bus.req_valid       = '0;
      bus.req_last        = '0;
      bus.re_credit_pulse = 1'b0;
      re_reset_n          = 1'b0;
      #1;
      chk({tag, " rst ready"}, 64'(bus.req_ready), 64'h0);
      chk({tag, " rst re_valid"}, 64'(bus.re_valid), 64'h0);
      chk({tag, " rst data_in"}, 64'(bus.data_in), 64'h0);
      chk({tag, " rst grant_id"}, 64'(grant_id), 64'd3);
      chk({tag, " rst credits"}, 64'(credit_count), 64'd16);
      chk({tag, " rst err"}, 64'(credit_err), 64'h0);
      chk({tag, " rst state"}, 64'(state_dbg), 64'h0);
      @(posedge re_clk);
      @(negedge re_clk);
      re_reset_n = 1'b1;
   endtask

   typedef struct packed {
      logic       en;
      logic [3:0] v;
      logic [3:0] l;
      logic       p;
      logic [3:0] ready;
      logic       rv;
      logic [1:0] gid;
      logic [4:0] cnt;
   } vec_t;

   localparam int NV = 15;
   vec_t tv[NV];

   // behavioural reference model state
   int          m_cnt;
   int          m_gid;
   bit          m_lock;
   bit          m_err;
   logic [31:0] m_data;

   initial begin
      logic [31:0] exp_data;
      int          xfers;

      re_reset_n          = 1'b0;
      arb_enable          = 1'b0;
      bus.req_valid       = '0;
      bus.req_last        = '0;
      bus.req_data        = '0;
      bus.re_credit_pulse = 1'b0;

      //         en  v     l     p   ready rv gid cnt
      tv[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 5'd16};
      tv[1]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 5'd16};
      tv[2]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 5'd16};
      tv[3]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 5'd16};
      tv[4]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 5'd16};
      tv[5]  = '{1'b1, 4'h2, 4'hF, 1'b0, 4'h2, 1'b1, 2'd1, 5'd15};
      tv[6]  = '{1'b1, 4'h7, 4'h0, 1'b0, 4'h4, 1'b1, 2'd2, 5'd14};
      tv[7]  = '{1'b0, 4'h7, 4'h0, 1'b0, 4'h0, 1'b0, 2'd2, 5'd14};
      tv[8]  = '{1'b1, 4'h3, 4'h0, 1'b0, 4'h0, 1'b0, 2'd2, 5'd14};
      tv[9]  = '{1'b1, 4'h7, 4'h0, 1'b0, 4'h4, 1'b1, 2'd2, 5'd13};
      tv[10] = '{1'b1, 4'h7, 4'h4, 1'b0, 4'h4, 1'b1, 2'd2, 5'd12};
      tv[11] = '{1'b1, 4'hB, 4'hF, 1'b0, 4'h8, 1'b1, 2'd3, 5'd11};
      tv[12] = '{1'b1, 4'hB, 4'hF, 1'b0, 4'h1, 1'b1, 2'd0, 5'd10};
      tv[13] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 5'd11};
      tv[14] = '{1'b1, 4'h0, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 5'd11};

      // ---- table-driven vectors: rotation, burst lock, stalls ----
      set_fixed_data();
      do_reset("tab");
      exp_data = 32'h0;
      for (int s = 0; s < NV; s++) begin
         apply(tv[s].en, tv[s].v, tv[s].l, tv[s].p);
         chk($sformatf("vec%0d ready", s), 64'(bus.req_ready), 64'(tv[s].ready));
         tick();
         if (tv[s].rv) exp_data = 32'hD000_0000 + 32'(tv[s].gid);
         chk($sformatf("vec%0d re_valid", s), 64'(bus.re_valid), 64'(tv[s].rv));
         chk($sformatf("vec%0d grant_id", s), 64'(grant_id), 64'(tv[s].gid));
         chk($sformatf("vec%0d credits", s), 64'(credit_count), 64'(tv[s].cnt));
         chk($sformatf("vec%0d data_in", s), 64'(bus.data_in), 64'(exp_data));
      end

      // ---- credit exhaustion with requester 0 only ----
      do_reset("drain");
      xfers = 0;
      for (int i = 0; i < 20; i++) begin
         apply(1'b1, 4'h1, 4'h1, 1'b0);
         if (bus.req_ready[0]) xfers++;
         tick();
      end
      chk("drain xfers", 64'(xfers), 64'd16);
      chk("drain credits", 64'(credit_count), 64'd0);
      apply(1'b1, 4'h1, 4'h1, 1'b1);
      chk("drain ready at 0", 64'(bus.req_ready), 64'h0);
      tick();
      chk("drain pulse at 0", 64'(credit_count), 64'd1);
      apply(1'b1, 4'h1, 4'h1, 1'b0);
      chk("drain ready after pulse", 64'(bus.req_ready), 64'h1);
      tick();
      chk("drain credits back 0", 64'(credit_count), 64'd0);
      chk("drain re_valid", 64'(bus.re_valid), 64'h1);

      // ---- simultaneous pulse and transfer, then overflow ----
      do_reset("ovf");
      for (int i = 0; i < 11; i++) begin
         apply(1'b1, 4'h1, 4'h1, 1'b0);
         tick();
      end
      chk("ovf credits 5", 64'(credit_count), 64'd5);
      apply(1'b1, 4'h1, 4'h1, 1'b1);
      chk("ovf ready", 64'(bus.req_ready), 64'h1);
      tick();
      chk("ovf same-cycle", 64'(credit_count), 64'd5);
      for (int i = 0; i < 11; i++) begin
         apply(1'b1, 4'h0, 4'h0, 1'b1);
         tick();
      end
      chk("ovf refill", 64'(credit_count), 64'd16);
      chk("ovf no err yet", 64'(credit_err), 64'h0);
      apply(1'b1, 4'h0, 4'h0, 1'b1);
      tick();
      chk("ovf err", 64'(credit_err), 64'h1);
      chk("ovf count held", 64'(credit_count), 64'd16);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 4'h1, 4'h1, 1'b0);
         tick();
      end
      chk("ovf err sticky", 64'(credit_err), 64'h1);

      // ---- reset during burst word 2 ----
      do_reset("mid");
      apply(1'b1, 4'h2, 4'h0, 1'b0);
      chk("mid w1 ready", 64'(bus.req_ready), 64'h2);
      tick();
      chk("mid burst state", 64'(state_dbg), 64'h1);
      apply(1'b1, 4'h2, 4'h0, 1'b0);
      chk("mid w2 ready", 64'(bus.req_ready), 64'h2);
      re_reset_n = 1'b0;
      #1;
      chk("mid rst ready", 64'(bus.req_ready), 64'h0);
      chk("mid rst state", 64'(state_dbg), 64'h0);
      chk("mid rst credits", 64'(credit_count), 64'd16);
      chk("mid rst re_valid", 64'(bus.re_valid), 64'h0);
      tick();
      chk("mid held re_valid", 64'(bus.re_valid), 64'h0);
      apply(1'b1, 4'h0, 4'h0, 1'b0);
      re_reset_n = 1'b1;
      tick();
      chk("mid no stray word", 64'(bus.re_valid), 64'h0);
      apply(1'b1, 4'h3, 4'hF, 1'b0);
      chk("mid first grant", 64'(bus.req_ready), 64'h1);
      tick();
      chk("mid grant_id", 64'(grant_id), 64'd0);

      // ---- randomized run against reference model ----
      do_reset("rnd");
      m_cnt = C; m_gid = N - 1; m_lock = 0; m_err = 0; m_data = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic [3:0]  v, l, er;
         logic        en, p;
         logic [31:0] d[N];
         int          w;
         en = ($urandom_range(0, 9) != 0);
         v  = 4'($urandom_range(0, 15));
         l  = 4'($urandom_range(0, 15));
         p  = (cyc < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
         @(negedge re_clk);
         for (int i = 0; i < N; i++) begin
            d[i] = $urandom;
            bus.req_data[i*W +: W] = d[i];
         end
         arb_enable = en; bus.req_valid = v; bus.req_last = l; bus.re_credit_pulse = p;
         #1;
         // rule: enabled, credit left; locked owner only, else rotate from last grant
         w = -1;
         if (en && m_cnt > 0) begin
            if (m_lock) begin
               if (v[m_gid]) w = m_gid;
            end else begin
               for (int k = 1; k <= N; k++)
                  if (w < 0 && v[(m_gid + k) % N]) w = (m_gid + k) % N;
            end
         end
         er = (w >= 0) ? 4'(1 << w) : 4'h0;
         chk($sformatf("rnd%0d ready", cyc), 64'(bus.req_ready), 64'(er));
         if (w >= 0) begin
            m_data = d[w];
            m_gid  = w;
            m_lock = !l[w];
         end
         if (p && w < 0 && m_cnt == C) m_err = 1;
         else m_cnt = m_cnt + (p ? 1 : 0) - ((w >= 0) ? 1 : 0);
         exp_q.push_back({(w >= 0), m_data, 2'(m_gid), 5'(m_cnt), m_err, m_lock});
         tick();
         chk($sformatf("rnd%0d regs", cyc),
             64'({bus.re_valid, bus.data_in, grant_id, credit_count, credit_err, state_dbg}),
             64'(exp_q.pop_front()));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
